// File: rtl/serial_shifter_pkg.sv
// rtl/serial_shifter_pkg.sv - shared opcodes, FSM encoding and width helper for serial_shifter
package serial_shifter_pkg;

    localparam logic OP_SHR = 1'b0;
    localparam logic OP_SHL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0, clog2(9) = 4
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_shifter_step.sv
// rtl/serial_shifter_step.sv - combinational one-bit shift used by the serial shifter datapath
module shift_step
    import serial_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted
);

    // Left shifts always bring in zero; right shifts bring in the fill bit
    always_comb begin
        shifted = value;
        if (dir == OP_SHL) begin
            shifted = {value[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {fill, value[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - one-bit-per-clock shifter with request/result handshakes (option: SERIAL_SHIFTER_ARITH_EN)
module serial_shifter
    import serial_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] b,
`ifdef SERIAL_SHIFTER_ARITH_EN
    input  logic             arith,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res
);

    localparam int CNT_W = clog2(WIDTH + 1);
    // Comparison width wide enough for both b and WIDTH so upper bits of b never alias
    localparam int CMP_W = (AMT_W > 32) ? AMT_W : 32;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] step_out;
    logic [WIDTH-1:0] res_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_init;
    logic [CNT_W-1:0] cnt_dec;
    logic [CMP_W-1:0] b_ext;
    logic             op_q;
    logic             fill;
    logic             accept;

    assign accept  = in_valid && in_ready;
    assign b_ext   = CMP_W'(b);
    assign cnt_dec = cnt - CNT_W'(1);

    // Saturate the requested amount at WIDTH; larger shifts give the same result
    always_comb begin
        cnt_init = CNT_W'(WIDTH);
        if (b_ext < CMP_W'(WIDTH)) begin
            cnt_init = CNT_W'(b);
        end
    end

`ifdef SERIAL_SHIFTER_ARITH_EN
    logic arith_q;

    // Arithmetic right shift replicates the current MSB, which never changes during the operation
    always_comb begin
        fill = (op_q == OP_SHR) && arith_q && sreg[WIDTH-1];
    end
`else
    // Only logical shifts are available: vacated bits are always zero
    always_comb begin
        fill = 1'b0;
    end
`endif

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value  (sreg),
        .dir    (op_q),
        .fill   (fill),
        .shifted(step_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: zero-length requests skip SHIFT; the last shift step lands in DONE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (cnt_init != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_dec == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    assign res = res_q;

    // Datapath: latch request, shift once per SHIFT cycle, capture result on entry to DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg    <= '0;
            cnt     <= '0;
            op_q    <= OP_SHL;
            res_q   <= '0;
`ifdef SERIAL_SHIFTER_ARITH_EN
            arith_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sreg    <= a;
                        op_q    <= opcode;
                        cnt     <= cnt_init;
`ifdef SERIAL_SHIFTER_ARITH_EN
                        arith_q <= arith;
`endif
                        if (cnt_init == '0) begin
                            res_q <= a;
                        end
                    end
                end
                ST_SHIFT: begin
                    sreg <= step_out;
                    cnt  <= cnt_dec;
                    if (cnt_dec == '0) begin
                        res_q <= step_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
